matrix_pe_param: RTL and testbench

Parametrised successor to the matrix PE. It executes a dot-product micro-op over NUM_ITER beat pairs of neuron/weight vectors and returns one accumulated result per uop. It generalises vector width, element width and accumulator width, and adds a runtime int16/int8 lane mode. Its result output has a valid/ready handshake with backpressure. It sits between the NRAM/WRAM read ports, the instruction buffer and the result writeback.

---
 rtl/matrix_pe_pkg.sv | 31 +++
 rtl/mpe_dot_tree.sv | 85 ++++++++
 rtl/matrix_pe_param.sv | 130 +++++++++++++
 tb/tb_matrix_pe_param.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pe_pkg.sv
// Shared definitions for the parametrised matrix PE: FSM encodings, lane modes,
// micro-op field layout and lane-count helpers.
// Latency: n/a (package). Backpressure: n/a.
package matrix_pe_pkg;

  // FSM encodings (plain constants so older flows can read them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  // Lane mode carried in the top bit of the micro-op.
  localparam logic MODE_INT16 = 1'b0;
  localparam logic MODE_INT8  = 1'b1;

  // Micro-op layout: iteration count starts at bit 0, mode is the MSB.
  localparam int UOP_CNT_LSB = 0;

  function automatic int uop_mode_pos(input int uop_w);
    return uop_w - 1;
  endfunction

  function automatic int lanes16(input int data_w);
    return data_w / 16;
  endfunction

  function automatic int lanes8(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mpe_dot_tree.sv
// Mode-selectable signed lane multipliers followed by a registered adder tree.
// Latency: 2 cycles (stage 1 products, stage 2 sum); valid travels alongside the data.
// Backpressure: none, accepts a beat pair every cycle in_valid is high.
// Ports: clk/rst, in_valid + mode + neuron/weight beats in; s1_valid (stage-1
// occupancy), out_valid and out_sum (ACC_W, wraps) out.
module mpe_dot_tree
  import matrix_pe_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mode,
  input  logic [DATA_W-1:0] neuron,
  input  logic [DATA_W-1:0] weight,
  output logic              s1_valid,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum
);

  localparam int N8  = lanes8(DATA_W);
  localparam int N16 = lanes16(DATA_W);

  logic signed [15:0] p8  [N8];
  logic signed [31:0] p16 [N16];
  logic [ACC_W-1:0]   prod_d [N8];
  logic [ACC_W-1:0]   prod_q [N8];
  logic [ACC_W-1:0]   sum_d;

  // Full-precision lane products in both modes; the mode picks which set is used.
  for (genvar g = 0; g < N8; g++) begin : g_mul8
    assign p8[g] = 16'($signed(neuron[8*g +: 8])) * 16'($signed(weight[8*g +: 8]));
  end

  for (genvar g = 0; g < N16; g++) begin : g_mul16
    assign p16[g] = 32'($signed(neuron[16*g +: 16])) * 32'($signed(weight[16*g +: 16]));
  end

  // Product slots are shared: int8 uses all N8 slots, int16 the lower N16,
  // with the unused upper slots forced to zero so the tree sum stays correct.
  always_comb begin
    for (int i = 0; i < N8; i++) begin
      prod_d[i] = '0;
      if (mode == MODE_INT8) begin
        prod_d[i] = ACC_W'(p8[i]);
      end
    end
    if (mode == MODE_INT16) begin
      for (int j = 0; j < N16; j++) begin
        prod_d[j] = ACC_W'(p16[j]);
      end
    end
  end

  // Written as a linear reduction; synthesis rebalances it into a tree.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N8; i++) begin
      sum_d = sum_d + prod_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // Data registers only load alongside a valid; no reset needed.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      prod_q <= prod_d;
    end
    if (s1_valid) begin
      out_sum <= sum_d;
    end
  end

endmodule

// File: rtl/matrix_pe_param.sv
// Dot-product PE: accumulates NUM_ITER neuron/weight beat pairs per micro-op, one result each.
// Latency: result_valid 3 cycles after the last beat pair, 1 cycle after a NUM_ITER=0 uop.
// Backpressure: result held until result_ready; no uop or beats are accepted meanwhile.
// Ports: clk/rst; ib_ctl_uop(+valid/ready) micro-op in; nram_mpe_neuron and
// wram_mpe_weight (+valid/ready) beat streams in; result(+valid/ready) out.
module matrix_pe_param
  import matrix_pe_pkg::*;
#(
  parameter int   DATA_W = 512,
  parameter int   ACC_W  = 32,
  parameter int   UOP_W  = 8,
  localparam int  CNT_W  = UOP_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UOP_W-1:0]  ib_ctl_uop,
  input  logic              ib_ctl_uop_valid,
  output logic              ib_ctl_uop_ready,
  input  logic [DATA_W-1:0] nram_mpe_neuron,
  input  logic              nram_mpe_neuron_valid,
  output logic              nram_mpe_neuron_ready,
  input  logic [DATA_W-1:0] wram_mpe_weight,
  input  logic              wram_mpe_weight_valid,
  output logic              wram_mpe_weight_ready,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int MODE_POS = uop_mode_pos(UOP_W);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] uop_iter;
  logic             mode_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             beats_remaining;
  logic             fire;
  logic             s1_valid;
  logic             tree_valid;
  logic [ACC_W-1:0] tree_sum;

  assign uop_iter         = ib_ctl_uop[UOP_CNT_LSB +: CNT_W];
  assign ib_ctl_uop_ready = (state == ST_IDLE);
  assign beats_remaining  = (cnt != '0);

  // Each ready depends on the other stream's valid so both fire together.
  assign nram_mpe_neuron_ready = (state == ST_RUN) && wram_mpe_weight_valid && beats_remaining;
  assign wram_mpe_weight_ready = (state == ST_RUN) && nram_mpe_neuron_valid && beats_remaining;
  assign fire = (state == ST_RUN) && nram_mpe_neuron_valid && wram_mpe_weight_valid
                && beats_remaining;

  mpe_dot_tree #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fire),
    .mode      (mode_q),
    .neuron    (nram_mpe_neuron),
    .weight    (wram_mpe_weight),
    .s1_valid  (s1_valid),
    .out_valid (tree_valid),
    .out_sum   (tree_sum)
  );

  always_comb begin
    acc_next = acc;
    if (tree_valid) begin
      acc_next = acc + tree_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      mode_q       <= MODE_INT16;
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (tree_valid) begin
        acc <= acc_next;
      end
      case (state)
        ST_IDLE: begin
          if (ib_ctl_uop_valid) begin
            mode_q <= ib_ctl_uop[MODE_POS];
            cnt    <= uop_iter;
            if (uop_iter == '0) begin
              state        <= ST_OUT;
              result       <= '0;
              result_valid <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (fire) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Once stage 1 is empty, the last partial sum is in stage 2 and is
          // folded straight into the result on this edge.
          if (!s1_valid) begin
            state        <= ST_OUT;
            result       <= acc_next;
            result_valid <= 1'b1;
          end
        end
        default: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            acc          <= '0;
            state        <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_pe_param.sv
module tb_matrix_pe_param;

  localparam int DATA_W = 512;
  localparam int ACC_W  = 32;
  localparam int UOP_W  = 8;

  logic              clk;
  logic              rst;
  logic [UOP_W-1:0]  ib_ctl_uop;
  logic              ib_ctl_uop_valid;
  logic              ib_ctl_uop_ready;
  logic [DATA_W-1:0] nram_mpe_neuron;
  logic              nram_mpe_neuron_valid;
  logic              nram_mpe_neuron_ready;
  logic [DATA_W-1:0] wram_mpe_weight;
  logic              wram_mpe_weight_valid;
  logic              wram_mpe_weight_ready;
  logic [ACC_W-1:0]  result;
  logic              result_valid;
  logic              result_ready;

  matrix_pe_param #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .UOP_W  (UOP_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ib_ctl_uop            (ib_ctl_uop),
    .ib_ctl_uop_valid      (ib_ctl_uop_valid),
    .ib_ctl_uop_ready      (ib_ctl_uop_ready),
    .nram_mpe_neuron       (nram_mpe_neuron),
    .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
    .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
    .wram_mpe_weight       (wram_mpe_weight),
    .wram_mpe_weight_valid (wram_mpe_weight_valid),
    .wram_mpe_weight_ready (wram_mpe_weight_ready),
    .result                (result),
    .result_valid          (result_valid),
    .result_ready          (result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int last_pair_cyc = 0;
  int last_uop_cyc  = 0;
  int cur_n = 0;

  logic [31:0] sb [$];
  logic [DATA_W-1:0] nb [128];
  logic [DATA_W-1:0] wb [128];
  logic [31:0] last_result;

  // Values sampled in the current cycle, just before the active edge.
  bit s_nf, s_wf, s_uf, s_rf, s_rv, s_nr, s_wr, s_uop_rdy, rv_prev;
  logic [31:0] s_res;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Golden dot product over the first n beat pairs held in nb/wb.
  function automatic logic [31:0] model(input logic mode, input int n);
    logic signed [31:0] s, xs, ys;
    logic signed [15:0] x16, y16;
    logic signed [7:0]  x8, y8;
    s = 0;
    for (int b = 0; b < n; b++) begin
      if (mode) begin
        for (int i = 0; i < DATA_W/8; i++) begin
          x8 = nb[b][8*i +: 8];
          y8 = wb[b][8*i +: 8];
          xs = x8;
          ys = y8;
          s  = s + xs * ys;
        end
      end else begin
        for (int i = 0; i < DATA_W/16; i++) begin
          x16 = nb[b][16*i +: 16];
          y16 = wb[b][16*i +: 16];
          xs  = x16;
          ys  = y16;
          s   = s + xs * ys;
        end
      end
    end
    return s;
  endfunction

  // pat 0: int16 1*2, 1: int8 -1*3, 2: random, 3: int16 0x7FFF*0x7FFF
  task automatic fill(input int pat);
    for (int b = 0; b < 128; b++) begin
      for (int w = 0; w < DATA_W/32; w++) begin
        case (pat)
          0: begin nb[b][32*w +: 32] = 32'h0001_0001; wb[b][32*w +: 32] = 32'h0002_0002; end
          1: begin nb[b][32*w +: 32] = 32'hFFFF_FFFF; wb[b][32*w +: 32] = 32'h0303_0303; end
          2: begin nb[b][32*w +: 32] = $urandom;      wb[b][32*w +: 32] = $urandom;      end
          default: begin nb[b][32*w +: 32] = 32'h7FFF_7FFF; wb[b][32*w +: 32] = 32'h7FFF_7FFF; end
        endcase
      end
    end
  endtask

  // Inputs are set at the falling edge; sample 1ns later, then cross the rising edge.
  task automatic tick();
    #1;
    s_nr = nram_mpe_neuron_ready;
    s_wr = wram_mpe_weight_ready;
    s_uop_rdy = ib_ctl_uop_ready;
    s_nf = nram_mpe_neuron_valid && nram_mpe_neuron_ready;
    s_wf = wram_mpe_weight_valid && wram_mpe_weight_ready;
    s_uf = ib_ctl_uop_valid && ib_ctl_uop_ready;
    s_rv = result_valid;
    s_rf = result_valid && result_ready;
    s_res = result;
    if (s_nf && s_wf) last_pair_cyc = cyc;
    if (s_uf) last_uop_cyc = cyc;
    if (s_rv && !rv_prev)
      check("latency", cyc - ((cur_n == 0) ? last_uop_cyc : last_pair_cyc),
            (cur_n == 0) ? 1 : 3);
    rv_prev = s_rv;
    if (s_rf) begin
      if (sb.size() == 0) begin
        check("spurious_result", result_valid, 0);
      end else begin
        last_result = result;
        check("result", result, sb.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_uop(input logic mode, input int n, input bit rnd, input int hold);
    int k = 0, nfc = 0, wfc = 0, budget = 0, hold_left = hold;
    bit issued = 0, taken = 0, rdy_seen = 0, hold_bad = 0;
    logic [31:0] held = '0;
    sb.push_back(model(mode, n));
    cur_n = n;
    while (!taken && budget < 3000) begin
      ib_ctl_uop_valid = !issued && (!rnd || $urandom_range(1) == 1);
      ib_ctl_uop = issued ? 8'($urandom) : {mode, 7'(n)};
      nram_mpe_neuron_valid = issued && k < n && (!rnd || $urandom_range(1) == 1);
      wram_mpe_weight_valid = issued && k < n && (!rnd || $urandom_range(1) == 1);
      nram_mpe_neuron = (k < n) ? nb[k] : '0;
      wram_mpe_weight = (k < n) ? wb[k] : '0;
      result_ready = (hold_left > 0) ? 1'b0 : (!rnd || $urandom_range(1) == 1);
      tick();
      if (s_uf) issued = 1;
      if (s_nf) nfc++;
      if (s_wf) wfc++;
      if (s_nf && s_wf) k++;
      if (s_nr || s_wr) rdy_seen = 1;
      if (s_rv && hold_left > 0) begin
        if (hold_left == hold) held = s_res;
        else if (s_res !== held) hold_bad = 1;
        if (s_uop_rdy || s_nr || s_wr) hold_bad = 1;
        hold_left--;
      end
      if (s_rf) begin
        taken = 1;
        check("uop_rdy_on_take", s_uop_rdy, 0);
      end
      budget++;
    end
    check("timeout", taken, 1);
    check("neuron_fires", nfc, n);
    check("weight_fires", wfc, n);
    if (n == 0) check("no_ready_n0", rdy_seen, 0);
    if (hold > 0) check("hold_stable", hold_bad, 0);
    ib_ctl_uop_valid = 0;
    nram_mpe_neuron_valid = 0;
    wram_mpe_weight_valid = 0;
    result_ready = 0;
    tick();
    check("uop_rdy_after", s_uop_rdy, 1);
  endtask

  initial begin
    int budget;
    rst = 1;
    ib_ctl_uop = '0;
    ib_ctl_uop_valid = 0;
    nram_mpe_neuron = '0;
    nram_mpe_neuron_valid = 1;
    wram_mpe_weight = '0;
    wram_mpe_weight_valid = 1;
    result_ready = 0;
    rv_prev = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    tick();
    check("rst_uop_ready", s_uop_rdy, 1);
    check("rst_result_valid", s_rv, 0);
    check("rst_result", s_res, 0);
    check("rst_neuron_ready", s_nr, 0);
    check("rst_weight_ready", s_wr, 0);
    nram_mpe_neuron_valid = 0;
    wram_mpe_weight_valid = 0;

    // int16, 4 beats, 1*2 in every lane
    fill(0);
    do_uop(1'b0, 4, 0, 0);
    check("int16_const", last_result, 32'd256);

    // int8, 1 beat, -1*3 in every lane
    fill(1);
    do_uop(1'b1, 1, 0, 0);
    check("int8_const", last_result, 32'hFFFF_FF40);

    // random valids, random data and modes
    fill(2); do_uop(1'($urandom), 3, 1, 0);
    fill(2); do_uop(1'($urandom), 5, 1, 0);
    fill(2); do_uop(1'($urandom), 1, 1, 0);
    fill(2); do_uop(1'($urandom), 7, 1, 0);

    // result backpressure
    fill(2);
    do_uop(1'b1, 2, 0, 10);

    // zero iterations
    do_uop(1'b0, 0, 0, 0);
    check("zero_result", last_result, 0);

    // maximum iteration count at the largest int16 products
    fill(3);
    do_uop(1'b0, 127, 0, 0);
    check("max_wrap", last_result, 32'hF020_0FE0);

    // reset in the middle of RUN
    fill(2);
    cur_n = 10;
    ib_ctl_uop = {1'b0, 7'd10};
    ib_ctl_uop_valid = 1;
    budget = 0;
    while (budget < 20) begin
      tick();
      budget++;
      if (s_uf) break;
    end
    check("abort_uop_taken", s_uf, 1);
    ib_ctl_uop_valid = 0;
    for (int b = 0; b < 3; b++) begin
      nram_mpe_neuron = nb[b];
      wram_mpe_weight = wb[b];
      nram_mpe_neuron_valid = 1;
      wram_mpe_weight_valid = 1;
      tick();
    end
    nram_mpe_neuron_valid = 0;
    wram_mpe_weight_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    nram_mpe_neuron_valid = 1;
    wram_mpe_weight_valid = 1;
    tick();
    check("abort_result_valid", s_rv, 0);
    check("abort_result", s_res, 0);
    check("abort_uop_ready", s_uop_rdy, 1);
    check("abort_neuron_ready", s_nr, 0);
    nram_mpe_neuron_valid = 0;
    wram_mpe_weight_valid = 0;
    for (int d = 0; d < 4; d++) begin
      tick();
      check("abort_no_result", s_rv, 0);
    end
    fill(2);
    do_uop(1'b0, 2, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
